// File: rtl/anim_sprite_renderer.sv
// Animated sprite renderer: hit test, ROM addressing and a fixed 3-clock pixel pipeline.
// Optional horizontal mirroring is enabled by defining ANIM_SPRITE_HFLIP_EN.
module anim_sprite_renderer #(
  parameter int SPR_W           = 100,
  parameter int SPR_H           = 220,
  parameter int FRAMES          = 4,
  parameter int IDX_W           = 3,
  parameter int ADDR_W          = 17,
  parameter int TRANSP_IDX      = 1,
  parameter int TICKS_PER_FRAME = 8,
  parameter int SCALE_LOG2      = 0
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              frame_tick,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic              anim_en,
  input  logic              anim_restart,
`ifdef ANIM_SPRITE_HFLIP_EN
  input  logic              hflip,
`endif
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pal_index,
  input  logic [3:0]        pal_red,
  input  logic [3:0]        pal_green,
  input  logic [3:0]        pal_blue,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              opaque
);

  localparam int FRM_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int TCK_W = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;

  localparam logic [10:0]       SPAN_X     = 11'(SPR_W << SCALE_LOG2);
  localparam logic [10:0]       SPAN_Y     = 11'(SPR_H << SCALE_LOG2);
  localparam logic [ADDR_W-1:0] FRAME_SZ   = ADDR_W'(SPR_W * SPR_H);
  localparam logic [ADDR_W-1:0] ROW_SZ     = ADDR_W'(SPR_W);
  localparam logic [FRM_W-1:0]  FRAME_LAST = FRM_W'(FRAMES - 1);
  localparam logic [TCK_W-1:0]  TICK_LAST  = TCK_W'(TICKS_PER_FRAME - 1);
  localparam logic [IDX_W-1:0]  TRANSP     = IDX_W'(TRANSP_IDX);

  logic [9:0]        sx, sy;
  logic [FRM_W-1:0]  frame;
  logic [TCK_W-1:0]  tick;
  logic              v1, v2;

  logic [10:0]       px, py, ox, oy;
  logic [10:0]       col_raw, col, row;
  logic              hit;
  logic [ADDR_W-1:0] addr_d;

  // Shadow position and animation state only move on the vblank tick.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      sx    <= '0;
      sy    <= '0;
      tick  <= '0;
      frame <= '0;
    end else begin
      if (frame_tick) begin
        sx <= pos_x;
        sy <= pos_y;
      end
      if (anim_restart) begin
        tick  <= '0;
        frame <= '0;
      end else if (frame_tick && anim_en) begin
        if (tick == TICK_LAST) begin
          tick  <= '0;
          frame <= (frame == FRAME_LAST) ? '0 : frame + 1'b1;
        end else begin
          tick <= tick + 1'b1;
        end
      end
    end
  end

`ifdef ANIM_SPRITE_HFLIP_EN
  localparam logic [10:0] COL_LAST = 11'(SPR_W - 1);
  logic flip_q;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n)
      flip_q <= 1'b0;
    else if (frame_tick)
      flip_q <= hflip;
  end

  assign col = flip_q ? (COL_LAST - col_raw) : col_raw;
`else
  assign col = col_raw;
`endif

  // 11-bit compare so a sprite hanging off the right/bottom edge never wraps.
  assign px = {1'b0, DrawX};
  assign py = {1'b0, DrawY};
  assign ox = {1'b0, sx};
  assign oy = {1'b0, sy};

  assign hit = (px >= ox) && (px < ox + SPAN_X) &&
               (py >= oy) && (py < oy + SPAN_Y);

  assign col_raw = (px - ox) >> SCALE_LOG2;
  assign row     = (py - oy) >> SCALE_LOG2;

  assign addr_d = hit ? (ADDR_W'(frame) * FRAME_SZ + ADDR_W'(row) * ROW_SZ + ADDR_W'(col))
                      : '0;

  assign pal_index = rom_q;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr <= '0;
      v1       <= 1'b0;
      v2       <= 1'b0;
      red      <= '0;
      green    <= '0;
      blue     <= '0;
      opaque   <= 1'b0;
    end else begin
      rom_addr <= addr_d;
      v1       <= hit & blank;
      v2       <= v1;
      // rom_q lines up with v2: the ROM registered the address on the previous edge.
      if (v2 && (rom_q != TRANSP)) begin
        red    <= pal_red;
        green  <= pal_green;
        blue   <= pal_blue;
        opaque <= 1'b1;
      end else begin
        red    <= '0;
        green  <= '0;
        blue   <= '0;
        opaque <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_anim_sprite_renderer.sv
// Directed bench for anim_sprite_renderer: main instance (scale 1x) plus a 2x-scaled instance.
// Hflip vectors are included when ANIM_SPRITE_HFLIP_EN is defined.
module tb_anim_sprite_renderer;

  logic        vga_clk = 1'b0;
  logic        reset_n;
  logic [9:0]  DrawX, DrawY, pos_x, pos_y;
  logic        blank, frame_tick, anim_en, anim_restart;
`ifdef ANIM_SPRITE_HFLIP_EN
  logic        hflip;
`endif
  logic [16:0] rom_addr, rom_addr_sc;
  logic [2:0]  rom_q, rom_q_sc, pal_index, pal_index_sc;
  logic [3:0]  red, green, blue, red_sc, green_sc, blue_sc;
  logic        opaque, opaque_sc;

  int n_vec = 0;
  int n_err = 0;

  always #5 vga_clk = ~vga_clk;

  function automatic logic [3:0] pr(input logic [2:0] i); return {1'b1, i};  endfunction
  function automatic logic [3:0] pg(input logic [2:0] i); return {i, 1'b0};  endfunction
  function automatic logic [3:0] pb(input logic [2:0] i); return {1'b0, ~i}; endfunction

  // Synchronous ROM: texel index is the low three address bits.
  always @(posedge vga_clk) begin
    rom_q    <= rom_addr[2:0];
    rom_q_sc <= rom_addr_sc[2:0];
  end

  anim_sprite_renderer #(.TICKS_PER_FRAME(2), .SCALE_LOG2(0)) u_dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .frame_tick(frame_tick), .pos_x(pos_x), .pos_y(pos_y), .anim_en(anim_en),
    .anim_restart(anim_restart),
`ifdef ANIM_SPRITE_HFLIP_EN
    .hflip(hflip),
`endif
    .rom_addr(rom_addr), .rom_q(rom_q), .pal_index(pal_index),
    .pal_red(pr(pal_index)), .pal_green(pg(pal_index)), .pal_blue(pb(pal_index)),
    .red(red), .green(green), .blue(blue), .opaque(opaque)
  );

  anim_sprite_renderer #(.TICKS_PER_FRAME(2), .SCALE_LOG2(1)) u_dut_sc (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .frame_tick(frame_tick), .pos_x(pos_x), .pos_y(pos_y), .anim_en(anim_en),
    .anim_restart(anim_restart),
`ifdef ANIM_SPRITE_HFLIP_EN
    .hflip(hflip),
`endif
    .rom_addr(rom_addr_sc), .rom_q(rom_q_sc), .pal_index(pal_index_sc),
    .pal_red(pr(pal_index_sc)), .pal_green(pg(pal_index_sc)), .pal_blue(pb(pal_index_sc)),
    .red(red_sc), .green(green_sc), .blue(blue_sc), .opaque(opaque_sc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] out_now();
    return 32'({red, green, blue, opaque});
  endfunction

  function automatic logic [31:0] out_exp(input logic opq, input logic [2:0] idx);
    return opq ? 32'({pr(idx), pg(idx), pb(idx), 1'b1}) : 32'd0;
  endfunction

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge vga_clk);
      #1;
    end
  endtask

  task automatic set_px(input logic [9:0] x, input logic [9:0] y, input logic b);
    DrawX = x;
    DrawY = y;
    blank = b;
  endtask

  task automatic ftick(input logic en, input logic rst);
    frame_tick   = 1'b1;
    anim_en      = en;
    anim_restart = rst;
    step();
    frame_tick   = 1'b0;
    anim_restart = 1'b0;
  endtask

  // Hold one pixel for three clocks: address after one, colour after three.
  task automatic pixel(input string tag, input logic [9:0] x, input logic [9:0] y,
                       input logic b, input int a_exp, input logic opq, input logic [2:0] idx);
    set_px(x, y, b);
    step();
    if (a_exp >= 0) chk({tag, "_addr"}, 32'(rom_addr), 32'(a_exp));
    step(2);
    chk({tag, "_pix"}, out_now(), out_exp(opq, idx));
  endtask

  initial begin
    reset_n = 1'b0;
    set_px(10'd0, 10'd0, 1'b0);
    frame_tick = 1'b0; anim_en = 1'b0; anim_restart = 1'b0;
    pos_x = 10'd0; pos_y = 10'd0;
`ifdef ANIM_SPRITE_HFLIP_EN
    hflip = 1'b0;
`endif
    step(2);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_pix", out_now(), 32'd0);
    reset_n = 1'b1;
    step();

    // Load shadow (0,260), then check latency with a single hit pixel between misses.
    pos_y = 10'd260;
    ftick(1'b0, 1'b0);
    set_px(10'd5, 10'd262, 1'b1);
    step();
    chk("lat_addr", 32'(rom_addr), 32'd205);
    set_px(10'd0, 10'd0, 1'b1);
    step();
    chk("lat_addr_miss", 32'(rom_addr), 32'd0);
    chk("lat_clk2", out_now(), 32'd0);
    step();
    chk("lat_clk3", out_now(), out_exp(1'b1, 3'd5));
    step();
    chk("lat_clk4", out_now(), 32'd0);

    pixel("transp", 10'd1, 10'd262, 1'b1, 201, 1'b0, 3'd0);
    pixel("blank", 10'd5, 10'd262, 1'b0, -1, 1'b0, 3'd0);

    // Animation: frame before each of 9 ticks is 0,0,1,1,2,2,3,3,0.
    set_px(10'd5, 10'd262, 1'b1);
    for (int k = 0; k < 9; k++) begin
      step();
      chk($sformatf("anim_%0d", k), 32'(rom_addr), 32'(205 + 22000 * ((k / 2) % 4)));
      ftick(1'b1, 1'b0);
    end
    ftick(1'b1, 1'b0);
    step();
    chk("anim_f1", 32'(rom_addr), 32'd22205);
    ftick(1'b1, 1'b1);
    step();
    chk("restart", 32'(rom_addr), 32'd205);
    ftick(1'b1, 1'b0);
    step();
    chk("restart_tick0", 32'(rom_addr), 32'd205);
    ftick(1'b1, 1'b0);
    step();
    chk("restart_tick1", 32'(rom_addr), 32'd22205);
    ftick(1'b0, 1'b0);
    step();
    chk("anim_hold", 32'(rom_addr), 32'd22205);

    // Reset with a frame-1 sprite pixel on the outputs.
    step(2);
    chk("pre_rst_pix", out_now(), out_exp(1'b1, 3'd5));
    reset_n = 1'b0;
    #2;
    chk("async_rst_pix", out_now(), 32'd0);
    chk("async_rst_addr", 32'(rom_addr), 32'd0);
    @(posedge vga_clk);
    #1;
    reset_n = 1'b1;
    ftick(1'b0, 1'b0);
    chk("rst_shadow", 32'(rom_addr), 32'd0);
    step();
    chk("rst_frame0", 32'(rom_addr), 32'd205);

    // Position change without a tick is invisible; after the tick it takes effect.
    pos_x = 10'd600;
    pixel("nolatch", 10'd5, 10'd262, 1'b1, 205, 1'b1, 3'd5);
    ftick(1'b0, 1'b0);
    pixel("clip639", 10'd639, 10'd262, 1'b1, 239, 1'b1, 3'd7);
    pixel("miss599", 10'd599, 10'd262, 1'b1, 0, 1'b0, 3'd0);
    pixel("left600", 10'd600, 10'd262, 1'b1, 200, 1'b1, 3'd0);
    pixel("row479", 10'd600, 10'd479, 1'b1, 21900, 1'b1, 3'd4);
    pixel("miss_y259", 10'd600, 10'd259, 1'b1, 0, 1'b0, 3'd0);
    pixel("old_x5", 10'd5, 10'd262, 1'b1, 0, 1'b0, 3'd0);

    // 2x instance, shadow (600,260).
    set_px(10'd603, 10'd262, 1'b1);
    step();
    chk("sc_col1", 32'(rom_addr_sc), 32'd101);
    set_px(10'd601, 10'd262, 1'b1);
    step();
    chk("sc_col0", 32'(rom_addr_sc), 32'd100);

    // Right edge with the sprite fully on screen.
    pos_x = 10'd500;
    ftick(1'b0, 1'b0);
    pixel("right_edge", 10'd599, 10'd262, 1'b1, 299, 1'b1, 3'd3);
    pixel("past_right", 10'd600, 10'd262, 1'b1, 0, 1'b0, 3'd0);
    set_px(10'd639, 10'd262, 1'b1);
    step();
    chk("sc_col69", 32'(rom_addr_sc), 32'd169);

`ifdef ANIM_SPRITE_HFLIP_EN
    hflip = 1'b1;
    ftick(1'b0, 1'b0);
    pixel("hflip_left", 10'd500, 10'd262, 1'b1, 299, 1'b1, 3'd3);
    pixel("hflip_right", 10'd599, 10'd262, 1'b1, 200, 1'b1, 3'd0);
    pixel("hflip_miss", 10'd600, 10'd262, 1'b1, 0, 1'b0, 3'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/anim_sprite_renderer.md
Name: anim_sprite_renderer

Overview:
- Parametrised sprite renderer for the VGA pixel pipeline. Draws one multi-frame animated sprite (torch flicker, mob walk cycles) at a runtime-movable screen position, with integer power-of-2 scaling and a transparent colour index.
- Sits between the VGA controller (DrawX/DrawY/blank) and the layer compositor.
- Drives an external synchronous sprite ROM and a combinational palette.
- Outputs registered RGB plus an opaque flag the compositor uses for layering.

Parameters:
- SPR_W, 100: sprite width in texels.
- SPR_H, 220: sprite height in texels.
- FRAMES, 4: animation frames stored back-to-back in ROM.
- IDX_W, 3: palette index width.
- ADDR_W, 17: ROM address width. Must satisfy 2^ADDR_W >= SPR_W*SPR_H*FRAMES.
- TRANSP_IDX, 1: palette index treated as transparent.
- TICKS_PER_FRAME, 8: frame_tick pulses per animation step. Must be >= 1.
- SCALE_LOG2, 0: each texel is drawn as (2^SCALE_LOG2)² screen pixels.

Ports:
- vga_clk  in  1  pixel clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- blank  in  1  1 = visible region.
- frame_tick  in  1  one-cycle pulse, once per video frame (start of vblank).
- pos_x  in  10  requested sprite left edge.
- pos_y  in  10  requested sprite top edge.
- anim_en  in  1  1 = animation advances.
- anim_restart  in  1  one-cycle pulse; restart animation at frame 0.
- rom_addr  out  ADDR_W  registered ROM address.
- rom_q  in  IDX_W  ROM data, valid one clock after rom_addr.
- pal_index  out  IDX_W  equals rom_q; drives the palette.
- pal_red  in  4  palette red output.
- pal_green  in  4  palette green output.
- pal_blue  in  4  palette blue output.
- red  out  4  pixel colour, registered.
- green  out  4  pixel colour, registered.
- blue  out  4  pixel colour, registered.
- opaque  out  1  1 = sprite covers this pixel.

Behaviour:
- Reset (async, reset_n=0) clears immediately: red/green/blue=0, opaque=0, rom_addr=0, frame=0, tick=0, shadow position=(0,0), pipeline valid bits=0.
- Shadow position:
  - pos_x/pos_y are captured into shadow registers only on cycles with frame_tick=1.
  - All drawing uses the shadows, so there is no mid-frame tearing.
  - New values are visible from the next active frame.
- Animation:
  - On frame_tick with anim_en=1:
    - If tick==TICKS_PER_FRAME-1: tick←0 and frame←(frame==FRAMES-1 ? 0 : frame+1).
    - Otherwise tick←tick+1.
  - With anim_en=0, tick and frame hold.
  - anim_restart forces tick←0, frame←0. It has priority over a simultaneous frame_tick advance. The shadow position still loads on that tick.
  - The frame value is sampled in stage 0; a change takes effect on the next pixel.
- Hit test (stage 0, combinational on DrawX/DrawY):
  - Uses 11-bit unsigned arithmetic, so there is no wrap.
  - Horizontal: sx ≤ DrawX < sx + (SPR_W<<SCALE_LOG2).
  - Vertical: sy ≤ DrawY < sy + (SPR_H<<SCALE_LOG2).
  - A sprite extending past 639/479 is clipped naturally.
- Address:
  - col = (DrawX−sx)>>SCALE_LOG2, row = (DrawY−sy)>>SCALE_LOG2.
  - addr = frame*SPR_W*SPR_H + row*SPR_W + col, truncated to ADDR_W.
  - On a miss, addr = 0.
- Pipeline (latency 3 clocks, fixed, from DrawX/DrawY/blank to red/green/blue/opaque):
  - Edge 1: rom_addr registered; hit&blank registered as v1.
  - Edge 2: external ROM produces rom_q; v1 moves to v2.
  - Edge 3: output registers load.
    - If v2=1 and rom_q≠TRANSP_IDX: RGB = pal_red/pal_green/pal_blue and opaque=1.
    - Otherwise: RGB=0 and opaque=0.
- Blank low: the pixel is a miss (RGB 0, opaque 0), independent of ROM contents.
- Back-to-back pixels stream at one per clock; no stalls exist.

Optional Feature:
- Macro: ANIM_SPRITE_HFLIP_EN.
- When defined:
  - Adds input port hflip (1 bit), latched into a shadow register on frame_tick like the position.
  - When the shadow is 1, col becomes SPR_W−1−col; the hit test is unchanged.
- When undefined:
  - The port does not exist and col is never mirrored.

Test Plan:
- Reset mid-stream:
  - Stimulus: reset_n=0 for 1 cycle while a sprite pixel is in flight.
  - Required: red/green/blue/opaque drop to 0 at once; frame reads 0 after release.
- Hit and latency:
  - Stimulus: shadow pos (0,260), scale 0, DrawX=5, DrawY=262, blank=1.
  - Required: rom_addr=205 one clock later; RGB equals palette of rom_q exactly 3 clocks after DrawX.
- Transparency and blank:
  - Stimulus: rom_q=TRANSP_IDX on a hit pixel; separately, blank=0 on a hit pixel.
  - Required: opaque=0 and RGB=0 in both cases.
- Animation:
  - Stimulus: TICKS_PER_FRAME=2, FRAMES=4, anim_en=1, 9 frame_ticks.
  - Required: frame sequence 0,0,1,1,2,2,3,3,0; same pixel's rom_addr rises by 22000 per step.
  - Stimulus: anim_restart together with a tick.
  - Required: frame=0.
- Position latch and clipping:
  - Stimulus: change pos_x to 600 mid-frame without a tick.
  - Required: no visible change.
  - Stimulus: after a frame_tick.
  - Required: DrawX=639 hits (col 39) and DrawX=599 misses.
- Scaling/flip:
  - Stimulus: SCALE_LOG2=1, DrawX=sx+3.
  - Required: col=1.
  - Stimulus: with ANIM_SPRITE_HFLIP_EN and hflip=1, DrawX=sx.
  - Required: col=SPR_W−1=99.
